// File: rtl/time_setter.sv
// time_setter: user set/adjust controller for the day/hour/minute counters.
//
// Walks the user through day -> hour -> minute fields using debounced
// single-cycle button pulses, edits shadow copies captured from the live
// counters, and commits all three fields with one parallel-load cycle.
// Counting is gated off while editing and during the commit cycle.
//
// Optional feature (compile-time macro TIME_SETTER_TIMEOUT_EN):
//   an inactivity counter aborts an edit session back to IDLE, without
//   loading, after TIMEOUT_CYCLES cycles with no button activity.

module time_setter #(
    parameter int unsigned DAY_MIN        = 1,
    parameter int unsigned DAY_MAX        = 7,
    parameter int unsigned HOUR_MAX       = 23,
    parameter int unsigned MIN_MAX        = 59,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic [2:0] cur_day,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       day_load,
    output logic [2:0] day_data,
    output logic       hour_load,
    output logic [4:0] hour_data,
    output logic       min_load,
    output logic [5:0] min_data,
    output logic       count_en,
    output logic [1:0] field
);

    // Field limits narrowed to the bus widths they are compared against.
    localparam logic [2:0] DayMin  = 3'(DAY_MIN);
    localparam logic [2:0] DayMax  = 3'(DAY_MAX);
    localparam logic [4:0] HourMax = 5'(HOUR_MAX);
    localparam logic [5:0] MinMax  = 6'(MIN_MAX);

    // Elaboration-time sanity checks on the configuration.
    if (DAY_MIN > DAY_MAX || DAY_MAX > 7) begin : g_bad_day_range
        $error("time_setter: invalid DAY_MIN/DAY_MAX");
    end
    if (HOUR_MAX > 31 || MIN_MAX > 63) begin : g_bad_field_range
        $error("time_setter: HOUR_MAX/MIN_MAX do not fit the data buses");
    end
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("time_setter: TIMEOUT_CYCLES must fit the 16-bit idle counter");
    end

    typedef enum logic [2:0] {
        StIdle,
        StEditDay,
        StEditHour,
        StEditMin,
        StCommit
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sh_day_q, sh_day_d;
    logic [4:0] sh_hour_q, sh_hour_d;
    logic [5:0] sh_min_q, sh_min_d;

    logic       load_q;
    logic       count_en_q;
    logic [1:0] field_q;

    logic       editing;
    logic       any_btn;
    logic       timeout_hit;

    // Wrapped increments; an out-of-range shadow snaps to the field minimum.
    logic [2:0] day_inc;
    logic [4:0] hour_inc;
    logic [5:0] min_inc;

    // Increment values for each shadow field.
    always_comb begin
        day_inc  = sh_day_q + 3'd1;
        hour_inc = sh_hour_q + 5'd1;
        min_inc  = sh_min_q + 6'd1;
        if (sh_day_q >= DayMax || sh_day_q < DayMin) begin
            day_inc = DayMin;
        end
        if (sh_hour_q >= HourMax) begin
            hour_inc = 5'd0;
        end
        if (sh_min_q >= MinMax) begin
            min_inc = 6'd0;
        end
    end

    assign editing = (state_q == StEditDay) || (state_q == StEditHour) ||
                     (state_q == StEditMin);
    assign any_btn = btn_mode | btn_inc | btn_set;

`ifdef TIME_SETTER_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Inactivity counter: cleared by any button, runs only while editing.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (any_btn || !editing) begin
            idle_cnt_d = 16'd0;
        end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    // Abort only on a quiet cycle; a pulse in the same cycle takes precedence.
    assign timeout_hit = editing && !any_btn &&
                         (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Inactivity counter register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            idle_cnt_q <= 16'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and shadow update; button priority is set > mode > inc.
    always_comb begin
        state_d   = state_q;
        sh_day_d  = sh_day_q;
        sh_hour_d = sh_hour_q;
        sh_min_d  = sh_min_q;

        unique case (state_q)
            StIdle: begin
                // Entering edit snapshots the live counters into the shadows.
                if (btn_mode) begin
                    state_d   = StEditDay;
                    sh_day_d  = cur_day;
                    sh_hour_d = cur_hour;
                    sh_min_d  = cur_min;
                end
            end
            StEditDay: begin
                if (btn_set) begin
                    state_d = StCommit;
                end else if (btn_mode) begin
                    state_d = StEditHour;
                end else if (btn_inc) begin
                    sh_day_d = day_inc;
                end
            end
            StEditHour: begin
                if (btn_set) begin
                    state_d = StCommit;
                end else if (btn_mode) begin
                    state_d = StEditMin;
                end else if (btn_inc) begin
                    sh_hour_d = hour_inc;
                end
            end
            StEditMin: begin
                if (btn_set || btn_mode) begin
                    state_d = StCommit;
                end else if (btn_inc) begin
                    sh_min_d = min_inc;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (timeout_hit) begin
            state_d = StIdle;
        end
    end

    // State and shadow registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= StIdle;
            sh_day_q  <= DayMin;
            sh_hour_q <= 5'd0;
            sh_min_q  <= 6'd0;
        end else begin
            state_q   <= state_d;
            sh_day_q  <= sh_day_d;
            sh_hour_q <= sh_hour_d;
            sh_min_q  <= sh_min_d;
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with state_q in the following cycle.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            load_q     <= 1'b0;
            count_en_q <= 1'b1;
            field_q    <= 2'd0;
        end else begin
            load_q     <= (state_d == StCommit);
            count_en_q <= (state_d == StIdle);
            unique case (state_d)
                StEditDay:  field_q <= 2'd1;
                StEditHour: field_q <= 2'd2;
                StEditMin:  field_q <= 2'd3;
                default:    field_q <= 2'd0;
            endcase
        end
    end

    assign day_load  = load_q;
    assign hour_load = load_q;
    assign min_load  = load_q;
    assign day_data  = sh_day_q;
    assign hour_data = sh_hour_q;
    assign min_data  = sh_min_q;
    assign count_en  = count_en_q;
    assign field     = field_q;

endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
- User-facing set/adjust controller; the write side of the day/hour/minute counters' load interface.
- Takes debounced single-cycle button pulses and walks the user through day, hour and minute fields, editing shadow copies.
- On commit, drives the counters' parallel-load strobes and data buses in one cycle.
- Also gates counting while editing, so the displayed time does not run during adjustment.

Parameters:
- DAY_MIN, 1, lowest day code (counter preset value).
- DAY_MAX, 7, highest day code; increment wraps to DAY_MIN.
- HOUR_MAX, 23, hour wrap point; increment wraps to 0.
- MIN_MAX, 59, minute wrap point; increment wraps to 0.
- TIMEOUT_CYCLES, 1000, idle cycles before auto-abort (used only with TIME_SETTER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- clear_n  in  1  asynchronous active-low reset
- btn_mode  in  1  one-cycle pulse: enter edit / advance to next field
- btn_inc  in  1  one-cycle pulse: increment current field
- btn_set  in  1  one-cycle pulse: commit shadow values
- cur_day  in  3  live day counter value (databus readback)
- cur_hour  in  5  live hour counter value
- cur_min  in  6  live minute counter value
- day_load  out  1  load strobe to day counter
- day_data  out  3  load value for day counter
- hour_load  out  1  load strobe to hour counter
- hour_data  out  5  load value for hour counter
- min_load  out  1  load strobe to minute counter
- min_data  out  6  load value for minute counter
- count_en  out  1  high = counters run; low while editing
- field  out  2  0 none, 1 day, 2 hour, 3 min (display blink select)

Behaviour:
- Reset (clear_n low, asynchronous):
  - State IDLE.
  - All load strobes 0; field = 0; count_en = 1.
  - Shadows sh_day = DAY_MIN, sh_hour = 0, sh_min = 0.
  - *_data outputs reflect the shadows at all times.
- States: IDLE, EDIT_DAY, EDIT_HOUR, EDIT_MIN, COMMIT.
- IDLE:
  - btn_mode moves to EDIT_DAY.
  - On that same edge, the shadows capture cur_day, cur_hour and cur_min.
  - btn_inc and btn_set are ignored.
- EDIT_DAY:
  - btn_inc: sh_day = DAY_MAX ? DAY_MIN : sh_day+1.
  - btn_mode moves to EDIT_HOUR.
  - btn_set moves to COMMIT.
- EDIT_HOUR:
  - btn_inc: sh_hour = HOUR_MAX ? 0 : +1.
  - btn_mode moves to EDIT_MIN.
  - btn_set moves to COMMIT.
- EDIT_MIN:
  - btn_inc: sh_min = MIN_MAX ? 0 : +1.
  - btn_mode moves to COMMIT.
  - btn_set moves to COMMIT.
- COMMIT:
  - Held for exactly one cycle; day_load, hour_load and min_load are all 1 in this cycle.
  - Unconditionally returns to IDLE; all buttons are ignored during COMMIT.
- Outputs are registered: load strobes go high the cycle after the edge that enters COMMIT, and are low in every other cycle.
- count_en:
  - 0 in all EDIT_* states and in COMMIT.
  - Returns to 1 in the cycle after COMMIT, so the counters load before resuming.
- field is 1, 2 or 3 in EDIT_DAY, EDIT_HOUR and EDIT_MIN respectively; 0 otherwise.
- Simultaneous button pulses: priority is btn_set > btn_mode > btn_inc; the losers are dropped, with no increment side effect.
- Out-of-range captured values:
  - cur_day = 0 is captured as-is.
  - The first inc from an out-of-range value sets the field to its minimum (DAY_MIN or 0).
  - cur_hour > HOUR_MAX and cur_min > MIN_MAX are handled the same way.
- A reset mid-edit discards the shadows; no load strobe is issued.

Optional Feature:
- TIME_SETTER_TIMEOUT_EN defined:
  - A 16-bit inactivity counter clears on any button pulse and increments each cycle while in an EDIT_* state.
  - When it reaches TIMEOUT_CYCLES-1, the block returns to IDLE with no load (abort).
  - count_en = 1 on the next cycle.
- Not defined: the counter is absent, and EDIT_* states are held indefinitely.

Test Plan:
- Reset, then idle 10 cycles -> all loads 0, count_en = 1, field = 0, day_data = 1.
- cur = {3, 14, 59}; mode, set -> COMMIT one cycle with day_data = 3, hour_data = 14, min_data = 59, all loads = 1 for exactly one cycle.
- cur_day = 6; mode, inc, inc, set -> day_data = 1 (6 to 7 to 1 wrap); hour and min unchanged.
- cur = {1, 23, 59}; mode, mode, inc, mode, inc, mode -> hour_data = 0, min_data = 0, COMMIT entered via the final mode.
- In EDIT_HOUR, btn_mode and btn_inc in the same cycle -> state EDIT_MIN, hour unchanged.
- With TIME_SETTER_TIMEOUT_EN and TIMEOUT_CYCLES = 20: mode, then no buttons -> IDLE after 20 cycles, no load pulse, count_en = 1.
- Reset asserted mid-EDIT_MIN -> no load pulse.
